// File: rtl/icon_tx_queue_pkg.sv
// ---------------------------------------------------------------------------
// icon_tx_queue_pkg
// Shared data types for the execution-unit transmit queue:
//   - exec-unit address/data words
//   - icon TX channel (addr/data/valid) and RX response channel (success)
//   - queue entry (addr, data, opx) and retry state machine encoding
// ---------------------------------------------------------------------------
package icon_tx_queue_pkg;

    localparam int EXEC_UNIT_ADDR_W = 8;
    localparam int EXEC_UNIT_DATA_W = 32;

    typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
    typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

    typedef struct packed {
        type_exec_unit_addr addr;
        type_exec_unit_data data;
        logic               valid;
    } type_icon_tx_channel;

    typedef struct packed {
        logic success;
    } type_icon_rx_channel;

    typedef struct packed {
        type_exec_unit_addr addr;
        type_exec_unit_data data;
        logic               opx;
    } type_icon_txq_entry;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        BACKOFF = 2'd2
    } type_icon_txq_state;

endpackage

// File: rtl/icon_txq_retry_ctrl.sv
// ---------------------------------------------------------------------------
// icon_txq_retry_ctrl
// Retry/backoff state machine for the icon transmit queue.
//   clk, srst  : clock, synchronous active-high reset
//   nonempty   : queue holds at least one entry
//   last       : queue holds exactly one entry
//   enq        : an enqueue is accepted this cycle
//   success    : interconnect accepted the presented packet
//   valid_en   : drive tx valid this cycle
//   pop        : the stored head is consumed this cycle
//   backoff    : state is BACKOFF
//   bypass     : the incoming packet is presented directly (empty queue)
// Optional feature macro: ICON_TXQ_BYPASS_EN (same-cycle bypass from IDLE).
// ---------------------------------------------------------------------------
module icon_txq_retry_ctrl
    import icon_tx_queue_pkg::*;
#(
    parameter int MAX_RETRIES    = 15,
    parameter int BACKOFF_CYCLES = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic nonempty,
    input  logic last,
    input  logic enq,
    input  logic success,
    output logic valid_en,
    output logic pop,
    output logic backoff,
    output logic bypass
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int BO_W    = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    localparam logic [BO_W-1:0]    BO_LOAD     = BO_W'(BACKOFF_CYCLES);

    type_icon_txq_state state_reg, state_next;
    logic [RETRY_W-1:0] retry_reg, retry_next, retry_inc;
    logic [BO_W-1:0]    bo_reg, bo_next;

    assign retry_inc = retry_reg + RETRY_W'(1);

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= IDLE;
            retry_reg <= '0;
            bo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
            bo_reg    <= bo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        bo_next    = bo_reg;
        valid_en   = 1'b0;
        pop        = 1'b0;
        backoff    = 1'b0;
        bypass     = 1'b0;
        unique case (state_reg)
            IDLE: begin
`ifdef ICON_TXQ_BYPASS_EN
                // Present the incoming packet straight away; a refusal
                // counts as the first retry of the now-stored entry.
                if (enq) begin
                    valid_en = 1'b1;
                    bypass   = 1'b1;
                    if (!success) begin
                        if (RETRY_LIMIT == RETRY_W'(1)) begin
                            state_next = BACKOFF;
                            bo_next    = BO_LOAD;
                        end else begin
                            state_next = SEND;
                            retry_next = RETRY_W'(1);
                        end
                    end
                end
`else
                if (enq) begin
                    state_next = SEND;
                end
`endif
            end
            SEND: begin
                valid_en = nonempty;
                if (nonempty) begin
                    if (success) begin
                        pop        = 1'b1;
                        retry_next = '0;
                        if (last && !enq) begin
                            state_next = IDLE;
                        end
                    end else if (retry_inc == RETRY_LIMIT) begin
                        state_next = BACKOFF;
                        retry_next = '0;
                        bo_next    = BO_LOAD;
                    end else begin
                        retry_next = retry_inc;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            BACKOFF: begin
                backoff = 1'b1;
                if (bo_reg == BO_W'(1)) begin
                    state_next = SEND;
                    bo_next    = '0;
                end else begin
                    bo_next = bo_reg - BO_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/icon_tx_queue.sv
// ---------------------------------------------------------------------------
// icon_tx_queue
// FIFO of outgoing ALU result packets presented on the icon TX channel.
// The head is retried until the interconnect signals success; after
// MAX_RETRIES consecutive refusals tx valid is held low for BACKOFF_CYCLES.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_enq_*               : producer packet (valid, addr, data, opx)
//   o_enq_ready           : queue not full
//   o_icon, o_icon_opx    : presented packet and its operand select
//   i_icon_rx             : same-cycle success response
//   o_count/full/empty    : occupancy status
//   o_backoff             : backoff window active
// Optional feature macro: ICON_TXQ_BYPASS_EN (zero-latency bypass when empty).
// ---------------------------------------------------------------------------
module icon_tx_queue
    import icon_tx_queue_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int MAX_RETRIES    = 15,
    parameter int BACKOFF_CYCLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enq_valid,
    input  type_exec_unit_addr     i_enq_addr,
    input  type_exec_unit_data     i_enq_data,
    input  logic                   i_enq_opx,
    output logic                   o_enq_ready,
    output type_icon_tx_channel    o_icon,
    output logic                   o_icon_opx,
    input  type_icon_rx_channel    i_icon_rx,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_backoff
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    type_icon_txq_entry mem [DEPTH];
    type_icon_txq_entry head_reg;
    type_icon_txq_entry enq_entry;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             nonempty, last;
    logic             enq_fire, write_fire, read_fire;
    logic             valid_en, pop, bypass;

    assign enq_entry = '{addr: i_enq_addr, data: i_enq_data, opx: i_enq_opx};

    assign nonempty    = (count_reg != '0);
    assign last        = (count_reg == CNT_W'(1));
    assign o_full      = (count_reg == CNT_W'(DEPTH));
    assign o_empty     = !nonempty;
    assign o_enq_ready = !o_full;
    assign o_count     = count_reg;

    assign enq_fire = i_enq_valid && o_enq_ready;
    // A bypassed packet that is accepted immediately never touches storage.
    assign write_fire  = enq_fire && !(bypass && i_icon_rx.success);
    assign read_fire   = pop;
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(read_fire);
    assign count_next  = count_reg + CNT_W'(write_fire) - CNT_W'(read_fire);

    icon_txq_retry_ctrl #(
        .MAX_RETRIES    (MAX_RETRIES),
        .BACKOFF_CYCLES (BACKOFF_CYCLES)
    ) u_retry_ctrl (
        .clk      (i_clk),
        .srst     (i_reset),
        .nonempty (nonempty),
        .last     (last),
        .enq      (enq_fire),
        .success  (i_icon_rx.success),
        .valid_en (valid_en),
        .pop      (pop),
        .backoff  (o_backoff),
        .bypass   (bypass)
    );

    always_ff @(posedge i_clk) begin
        if (write_fire) begin
            mem[wr_ptr_reg] <= enq_entry;
        end
    end

    // Registered head read. The array read at rd_ptr_next gives the next
    // head; when that slot is being written this very edge (queue about to
    // hold only the new entry) the incoming packet is forwarded instead.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(write_fire);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (write_fire && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= enq_entry;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    always_comb begin
        o_icon     = '0;
        o_icon_opx = 1'b0;
        if (bypass) begin
            o_icon.addr = i_enq_addr;
            o_icon.data = i_enq_data;
            o_icon_opx  = i_enq_opx;
        end else if (nonempty) begin
            o_icon.addr = head_reg.addr;
            o_icon.data = head_reg.data;
            o_icon_opx  = head_reg.opx;
        end
        // Nothing is offered to the interconnect while reset is applied.
        o_icon.valid = valid_en && !i_reset;
    end

endmodule

// File: tb/tb_icon_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_icon_tx_queue
// Scoreboard bench for icon_tx_queue (DEPTH=8, MAX_RETRIES=15,
// BACKOFF_CYCLES=4). Expected packets are queued when an enqueue is driven
// and compared when the DUT presents a packet that is accepted.
// Build with ICON_TXQ_BYPASS_EN to exercise the bypass variant.
// ---------------------------------------------------------------------------
module tb_icon_tx_queue;
    import icon_tx_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ICON_TXQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic                i_enq_valid;
    type_exec_unit_addr  i_enq_addr;
    type_exec_unit_data  i_enq_data;
    logic                i_enq_opx;
    logic                o_enq_ready;
    type_icon_tx_channel o_icon;
    logic                o_icon_opx;
    type_icon_rx_channel i_icon_rx;
    logic [CNT_W-1:0]    o_count;
    logic                o_full;
    logic                o_empty;
    logic                o_backoff;

    int n_cmp = 0;
    int n_bad = 0;
    int model_count;
    type_icon_txq_entry sb[$];

    always #5 i_clk = ~i_clk;

    icon_tx_queue #(
        .DEPTH          (DEPTH),
        .MAX_RETRIES    (15),
        .BACKOFF_CYCLES (4)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_enq_valid (i_enq_valid),
        .i_enq_addr  (i_enq_addr),
        .i_enq_data  (i_enq_data),
        .i_enq_opx   (i_enq_opx),
        .o_enq_ready (o_enq_ready),
        .o_icon      (o_icon),
        .o_icon_opx  (o_icon_opx),
        .i_icon_rx   (i_icon_rx),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_backoff   (o_backoff)
    );

    function automatic type_icon_txq_entry make_pkt(input int n);
        type_icon_txq_entry e;
        e.addr = type_exec_unit_addr'(n * 7 + 3);
        e.data = 32'hC0DE_0000 + type_exec_unit_data'(n);
        e.opx  = n[0];
        return e;
    endfunction

    function automatic type_icon_txq_entry cur_head();
        type_icon_txq_entry e;
        e.addr = o_icon.addr;
        e.data = o_icon.data;
        e.opx  = o_icon_opx;
        return e;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_enq(input logic v, input type_icon_txq_entry e);
        i_enq_valid = v;
        i_enq_addr  = e.addr;
        i_enq_data  = e.data;
        i_enq_opx   = e.opx;
    endtask

    task automatic do_reset();
        i_reset           = 1'b1;
        i_icon_rx.success = 1'b0;
        drive_enq(1'b0, '0);
        step();
        step();
        i_reset = 1'b0;
        sb.delete();
        model_count = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge i_clk);
        n_cmp++; if (o_empty !== 1'b1)     begin n_bad++; $display("FAIL reset_empty: got %b want 1", o_empty); end
        n_cmp++; if (o_enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_enq_ready); end
        n_cmp++; if (o_count !== '0)       begin n_bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_cmp++; if (o_full !== 1'b0)      begin n_bad++; $display("FAIL reset_full: got %b want 0", o_full); end
        n_cmp++; if (o_backoff !== 1'b0)   begin n_bad++; $display("FAIL reset_backoff: got %b want 0", o_backoff); end
        n_cmp++; if (o_icon !== '0 || o_icon_opx !== 1'b0) begin
            n_bad++; $display("FAIL reset_icon: got %h/%b want 0/0", o_icon, o_icon_opx);
        end
        step();
    endtask

`ifndef ICON_TXQ_BYPASS_EN
    task automatic test_single();
        type_icon_txq_entry a, exp;
        do_reset();
        a.addr = 8'h12; a.data = 32'h0000_DEAD; a.opx = 1'b1;
        i_icon_rx.success = 1'b1;
        drive_enq(1'b1, a);
        sb.push_back(a);
        @(negedge i_clk);
        n_cmp++; if (o_icon.valid !== 1'b0) begin n_bad++; $display("FAIL single_latency: valid got %b want 0", o_icon.valid); end
        step();
        drive_enq(1'b0, '0);
        @(negedge i_clk);
        n_cmp++;
        if (o_icon.valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL single_present: valid got %b want 1", o_icon.valid);
        end else begin
            exp = sb.pop_front();
            if (cur_head() !== exp) begin n_bad++; $display("FAIL single_data: got %h want %h", cur_head(), exp); end
        end
        step();
        @(negedge i_clk);
        n_cmp++;
        if (o_empty !== 1'b1 || o_icon.valid !== 1'b0 || o_count !== '0) begin
            n_bad++; $display("FAIL single_pop: empty %b valid %b count %0d want 1 0 0", o_empty, o_icon.valid, o_count);
        end
        i_icon_rx.success = 1'b0;
        step();
    endtask
`endif

`ifdef ICON_TXQ_BYPASS_EN
    task automatic test_bypass();
        type_icon_txq_entry a;
        do_reset();
        a.addr = 8'h12; a.data = 32'h0000_DEAD; a.opx = 1'b1;
        i_icon_rx.success = 1'b1;
        drive_enq(1'b1, a);
        @(negedge i_clk);
        n_cmp++; if (o_icon.valid !== 1'b1) begin n_bad++; $display("FAIL bypass_valid: got %b want 1", o_icon.valid); end
        n_cmp++; if (cur_head() !== a)     begin n_bad++; $display("FAIL bypass_data: got %h want %h", cur_head(), a); end
        n_cmp++; if (o_count !== '0)       begin n_bad++; $display("FAIL bypass_count_now: got %0d want 0", o_count); end
        step();
        drive_enq(1'b0, '0);
        i_icon_rx.success = 1'b0;
        @(negedge i_clk);
        n_cmp++;
        if (o_count !== '0 || o_empty !== 1'b1 || o_icon.valid !== 1'b0) begin
            n_bad++; $display("FAIL bypass_after: count %0d empty %b valid %b want 0 1 0", o_count, o_empty, o_icon.valid);
        end
        step();
    endtask
`endif

    task automatic test_fill();
        type_icon_txq_entry exp;
        int guard;
        do_reset();
        i_icon_rx.success = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_enq(1'b1, make_pkt(i));
            sb.push_back(make_pkt(i));
            step();
        end
        // Ninth packet must be refused.
        drive_enq(1'b1, make_pkt(90));
        @(negedge i_clk);
        n_cmp++; if (o_count !== CNT_W'(DEPTH)) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", o_count, DEPTH); end
        n_cmp++; if (o_full !== 1'b1)      begin n_bad++; $display("FAIL fill_full: got %b want 1", o_full); end
        n_cmp++; if (o_enq_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", o_enq_ready); end
        step();
        // Full: pop and enqueue in the same cycle, enqueue is blocked.
        drive_enq(1'b1, make_pkt(91));
        i_icon_rx.success = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_enq_ready !== 1'b0) begin n_bad++; $display("FAIL full_simul_ready: got %b want 0", o_enq_ready); end
        n_cmp++;
        if (o_icon.valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL full_simul_valid: got %b want 1", o_icon.valid);
        end else begin
            exp = sb.pop_front();
            if (cur_head() !== exp) begin n_bad++; $display("FAIL fill_order: got %h want %h", cur_head(), exp); end
        end
        step();
        // Count 7: simultaneous enqueue and dequeue keeps the count.
        drive_enq(1'b1, make_pkt(8));
        @(negedge i_clk);
        n_cmp++; if (o_count !== CNT_W'(7)) begin n_bad++; $display("FAIL count7_before: got %0d want 7", o_count); end
        sb.push_back(make_pkt(8));
        n_cmp++;
        if (o_icon.valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL count7_valid: got %b want 1", o_icon.valid);
        end else begin
            exp = sb.pop_front();
            if (cur_head() !== exp) begin n_bad++; $display("FAIL fill_order: got %h want %h", cur_head(), exp); end
        end
        step();
        drive_enq(1'b0, '0);
        @(negedge i_clk);
        n_cmp++; if (o_count !== CNT_W'(7)) begin n_bad++; $display("FAIL count7_after: got %0d want 7", o_count); end
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            if (o_icon.valid === 1'b1) begin
                exp = sb.pop_front();
                n_cmp++;
                if (cur_head() !== exp) begin n_bad++; $display("FAIL fill_order: got %h want %h", cur_head(), exp); end
            end
            step();
            @(negedge i_clk);
            guard++;
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL fill_drain_timeout: left %0d want 0", sb.size()); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL fill_drain_empty: got %b want 1", o_empty); end
        i_icon_rx.success = 1'b0;
        step();
    endtask

    task automatic test_backoff();
        type_icon_txq_entry b, c, exp;
        int n_send, n_bo;
        do_reset();
        b = make_pkt(200);
        c = make_pkt(201);
        n_send = 0;
        n_bo   = 0;
        for (int k = 0; k <= 21 - BYP; k++) begin
            drive_enq(1'b0, '0);
            if (k == 0) begin drive_enq(1'b1, b); sb.push_back(b); end
            if (k == 16 - BYP) begin drive_enq(1'b1, c); sb.push_back(c); end
            i_icon_rx.success = (k >= 20 - BYP);
            @(negedge i_clk);
            if (k == 0) begin
                n_cmp++;
                if (o_icon.valid !== 1'(BYP)) begin n_bad++; $display("FAIL backoff_first: valid got %b want %0d", o_icon.valid, BYP); end
            end
            if (k >= 1 - BYP && k <= 15 - BYP && o_icon.valid === 1'b1 && o_backoff === 1'b0) n_send++;
            if (k >= 16 - BYP && k <= 19 - BYP && o_icon.valid === 1'b0 && o_backoff === 1'b1) n_bo++;
            if (k == 18 - BYP) begin
                n_cmp++;
                if (o_count !== CNT_W'(2)) begin n_bad++; $display("FAIL backoff_enq: count got %0d want 2", o_count); end
            end
            if (k >= 20 - BYP) begin
                n_cmp++;
                if (o_icon.valid !== 1'b1 || sb.size() == 0) begin
                    n_bad++; $display("FAIL backoff_resume: valid got %b want 1", o_icon.valid);
                end else begin
                    exp = sb.pop_front();
                    if (cur_head() !== exp) begin n_bad++; $display("FAIL backoff_order: got %h want %h", cur_head(), exp); end
                end
            end
            step();
        end
        n_cmp++; if (n_send != 15) begin n_bad++; $display("FAIL backoff_send_cycles: got %0d want 15", n_send); end
        n_cmp++; if (n_bo != 4)    begin n_bad++; $display("FAIL backoff_cycles: got %0d want 4", n_bo); end
        drive_enq(1'b0, '0);
        i_icon_rx.success = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL backoff_empty: got %b want 1", o_empty); end
        step();
    endtask

    task automatic test_reset_midway();
        int guard;
        do_reset();
        i_icon_rx.success = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_enq(1'b1, make_pkt(300 + i));
            step();
        end
        drive_enq(1'b0, '0);
        guard = 0;
        @(negedge i_clk);
        while (o_backoff !== 1'b1 && guard < 40) begin
            step();
            @(negedge i_clk);
            guard++;
        end
        n_cmp++; if (o_backoff !== 1'b1) begin n_bad++; $display("FAIL rst_reach_backoff: got %b want 1", o_backoff); end
        n_cmp++; if (o_count !== CNT_W'(5)) begin n_bad++; $display("FAIL rst_count_before: got %0d want 5", o_count); end
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        @(negedge i_clk);
        n_cmp++;
        if (o_count !== '0 || o_empty !== 1'b1 || o_backoff !== 1'b0 || o_icon.valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_in_backoff: count %0d empty %b backoff %b valid %b want 0 1 0 0",
                              o_count, o_empty, o_backoff, o_icon.valid);
        end
        step();
        // Reset applied while a packet is being sent: nothing presented.
        drive_enq(1'b1, make_pkt(400));
        step();
        drive_enq(1'b0, '0);
        i_reset = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_icon.valid !== 1'b0) begin n_bad++; $display("FAIL rst_cycle_valid: got %b want 0", o_icon.valid); end
        step();
        i_reset = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL rst_send_empty: got %b want 1", o_empty); end
        step();
    endtask

    task automatic test_back_to_back();
        type_icon_txq_entry p, exp;
        logic enq, acc, popped;
        int guard;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            enq = ($urandom_range(0, 3) != 0);
            p   = make_pkt(1000 + c);
            drive_enq(enq, p);
            if (c < 150) i_icon_rx.success = ($urandom_range(0, 2) == 0);
            else         i_icon_rx.success = ($urandom_range(0, 2) != 0);
            @(negedge i_clk);
            n_cmp++;
            if (o_count !== CNT_W'(model_count)) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", o_count, model_count); end
            n_cmp++;
            if (o_enq_ready !== (model_count < DEPTH)) begin
                n_bad++; $display("FAIL b2b_ready: got %b want %b", o_enq_ready, (model_count < DEPTH));
            end
            acc = enq && (model_count < DEPTH);
            if (acc) sb.push_back(p);
            popped = (o_icon.valid === 1'b1) && i_icon_rx.success;
            if (popped) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL b2b_spurious: got packet %h want none", cur_head());
                end else begin
                    exp = sb.pop_front();
                    if (cur_head() !== exp) begin n_bad++; $display("FAIL b2b_order: got %h want %h", cur_head(), exp); end
                end
            end
            model_count = model_count + int'(acc) - int'(popped);
            step();
        end
        drive_enq(1'b0, '0);
        i_icon_rx.success = 1'b1;
        guard = 0;
        @(negedge i_clk);
        while (sb.size() != 0 && guard < 200) begin
            if (o_icon.valid === 1'b1) begin
                exp = sb.pop_front();
                n_cmp++;
                if (cur_head() !== exp) begin n_bad++; $display("FAIL b2b_order: got %h want %h", cur_head(), exp); end
            end
            step();
            @(negedge i_clk);
            guard++;
        end
        n_cmp++; if (sb.size() != 0)   begin n_bad++; $display("FAIL b2b_drain_timeout: left %0d want 0", sb.size()); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: got %b want 1", o_empty); end
        i_icon_rx.success = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifndef ICON_TXQ_BYPASS_EN
        test_single();
`else
        test_bypass();
`endif
        test_fill();
        test_backoff();
        test_reset_midway();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
